shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine_pkg.sv | 24 ++
 rtl/shift_engine_shift_step.sv | 55 +++++
 rtl/shift_engine.sv | 101 ++++++++++
 tb/tb_shift_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// Shared definitions for the iterative shift engine: operation codes and
// controller state encodings. Imported by the RTL and by the testbench.
package shift_engine_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SLL = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for the codes that rotate rather than shift.
  function automatic logic mode_is_rotate(input logic [MODE_W-1:0] m);
    return (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_engine_shift_step.sv
// shift_step: combinational single-position shift/rotate of a WIDTH-bit word.
// Produces the next word and the bit that left it. Unknown codes pass the
// word through with a zero carry.
// Rotates exist only when SHIFT_ENGINE_ROTATE_EN is defined; otherwise the
// rotate codes fall into the pass-through path and no rotate muxing is built.
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  y_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [WIDTH-1:0]  y_o,
  output logic              c_o
);

  logic signed [WIDTH-1:0] y_s;

  assign y_s = $signed(y_i);

  // Select the one-bit move for the requested operation.
  always_comb begin
    y_o = y_i;
    c_o = 1'b0;
    case (mode_i)
      MODE_SLL: begin
        y_o = {y_i[WIDTH-2:0], 1'b0};
        c_o = y_i[WIDTH-1];
      end
      MODE_SRL: begin
        y_o = {1'b0, y_i[WIDTH-1:1]};
        c_o = y_i[0];
      end
      MODE_SRA: begin
        y_o = $unsigned(y_s >>> 1);
        c_o = y_i[0];
      end
`ifdef SHIFT_ENGINE_ROTATE_EN
      MODE_ROL: begin
        y_o = {y_i[WIDTH-2:0], y_i[WIDTH-1]};
        c_o = y_i[WIDTH-1];
      end
      MODE_ROR: begin
        y_o = {y_i[0], y_i[WIDTH-1:1]};
        c_o = y_i[0];
      end
`endif
      default: begin
        y_o = y_i;
        c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// shift_engine: iterative shifter that moves the operand one bit position per
// clock. An accepted start captures a/amt/mode; done pulses amt+1 cycles
// later with the result on y and the last bit moved out on c.
// Optional feature macro: SHIFT_ENGINE_ROTATE_EN (enables ROL/ROR).
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [AMT_W-1:0]  amt,
  input  logic [MODE_W-1:0] mode,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  y,
  output logic              c
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               c_q, c_d;
  logic [AMT_W-1:0]   count_q, count_d;
  logic [MODE_W-1:0]  mode_q, mode_d;

  logic [WIDTH-1:0]   step_y;
  logic               step_c;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .y_i    (y_q),
    .mode_i (mode_q),
    .y_o    (step_y),
    .c_o    (step_c)
  );

  // Next-state, datapath load/step and status outputs.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    c_d     = c_q;
    count_d = count_q;
    mode_d  = mode_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          y_d     = a;
          c_d     = 1'b0;
          count_d = amt;
          mode_d  = mode;
          // A zero count has nothing to shift, so go straight to DONE.
          state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        y_d     = step_y;
        c_d     = step_c;
        count_d = count_q - 1'b1;
        if (count_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      c_q     <= 1'b0;
      count_q <= '0;
      mode_q  <= MODE_SLL;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      c_q     <= c_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign y = y_q;
  assign c = c_q;

endmodule

// File: tb/tb_shift_engine.sv
// Testbench for shift_engine: directed vectors plus randomized operations
// compared against an arithmetic reference model.
module tb_shift_engine;
  import shift_engine_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [AW-1:0] amt;
  logic [2:0]    mode;
  logic          busy;
  logic          done;
  logic [W-1:0]  y;
  logic          c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_engine #(
    .WIDTH (W),
    .AMT_W (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .amt   (amt),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .c     (c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Whole-operation result computed directly from the shift count.
  function automatic void model(input logic [W-1:0] a_v, input int n, input int m,
                                output logic [W-1:0] ye, output logic ce);
    int av;
    int sv;
    int r;
    av = int'(a_v);
    sv = (av >= 128) ? av - 256 : av;
    r  = av;
    ce = 1'b0;
    case (m)
      0: begin
        r  = (av << n) & 255;
        ce = (n > 0) ? 1'((av >> (W - n)) & 1) : 1'b0;
      end
      1: begin
        r  = av >> n;
        ce = (n > 0) ? 1'((av >> (n - 1)) & 1) : 1'b0;
      end
      2: begin
        r  = (sv >>> n) & 255;
        ce = (n > 0) ? 1'((sv >>> (n - 1)) & 1) : 1'b0;
      end
`ifdef SHIFT_ENGINE_ROTATE_EN
      3: begin
        r  = ((av << n) | (av >> (W - n))) & 255;
        ce = (n > 0) ? 1'(r & 1) : 1'b0;
      end
      4: begin
        r  = ((av >> n) | (av << (W - n))) & 255;
        ce = (n > 0) ? 1'((r >> 7) & 1) : 1'b0;
      end
`endif
      default: begin
        r  = av;
        ce = 1'b0;
      end
    endcase
    ye = 8'(r);
  endfunction

  // One operation; poke pulses start while busy and again in the done cycle.
  task automatic do_op(input logic [W-1:0] av, input int n, input int m, input bit poke);
    logic [W-1:0] ye;
    logic         ce;
    int           cyc;
    model(av, n, m, ye, ce);
    @(negedge clk);
    a     = av;
    amt   = AW'(n);
    mode  = 3'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    amt   = AW'($urandom);
    mode  = 3'($urandom);
    cyc   = 1;
    check("busy_after_start", 32'(busy), 1);
    while (!done && cyc < 20) begin
      if (poke && cyc == 2) begin
        start = 1'b1;
        a     = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", 32'(cyc), 32'(n + 1));
      check("y", 32'(y), 32'(ye));
      check("c", 32'(c), 32'(ce));
      check("busy_in_done", 32'(busy), 1);
      if (poke) begin
        start = 1'b1;
        a     = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);
      check("y_hold", 32'(y), 32'(ye));
      check("c_hold", 32'(c), 32'(ce));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    amt   = '0;
    mode  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(y), 0);
    check("rst_c", 32'(c), 0);
    reset = 1'b0;

    do_op(8'h81, 1, int'(MODE_SLL), 1'b0);
    do_op(8'h90, 3, int'(MODE_SRA), 1'b0);
    do_op(8'h90, 5, int'(MODE_SRL), 1'b0);
    for (int m = 0; m < 5; m++) do_op(8'h5A, 0, m, 1'b0);
`ifdef SHIFT_ENGINE_ROTATE_EN
    do_op(8'h81, 1, int'(MODE_ROL), 1'b0);
`else
    do_op(8'h81, 2, int'(MODE_ROR), 1'b0);
`endif
    do_op(8'hC3, 4, 6, 1'b0);
    do_op(8'hB7, 7, int'(MODE_SLL), 1'b1);

    // Abort a long operation three cycles in.
    @(negedge clk);
    a     = 8'hFF;
    amt   = 3'd7;
    mode  = MODE_SLL;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_y", 32'(y), 0);
    check("abort_c", 32'(c), 0);
    check("abort_busy", 32'(busy), 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 0);

    // Reset and start in the same cycle: reset wins.
    a     = 8'hFF;
    amt   = 3'd0;
    mode  = MODE_SRL;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", 32'(busy), 0);
    check("rst_start_y", 32'(y), 0);
    @(negedge clk);
    check("rst_start_done", 32'(done), 0);

    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
